// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two requesters and the register-file write stage.
// Also carries the hazard-check lookup and the commit counter.
interface regfile_wb_arbiter_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  logic              stall;
  logic              req0_valid;
  logic              req1_valid;
  logic [AWIDTH-1:0] req0_addr;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH-1:0] req0_data;
  logic [DWIDTH-1:0] req1_data;
  logic              req0_ready;
  logic              req1_ready;
  logic              RegWEn;
  logic [AWIDTH-1:0] AddrD;
  logic [DWIDTH-1:0] DataD;
  logic              grant_id;
  logic [AWIDTH-1:0] chk_addr_a;
  logic [AWIDTH-1:0] chk_addr_b;
  logic              hazard_a;
  logic              hazard_b;
  logic [15:0]       wr_count;

  // Pipeline/requester side drives requests and lookups.
  modport master (
    output stall, req0_valid, req1_valid, req0_addr, req1_addr,
           req0_data, req1_data, chk_addr_a, chk_addr_b,
    input  req0_ready, req1_ready, RegWEn, AddrD, DataD, grant_id,
           hazard_a, hazard_b, wr_count
  );

  modport slave (
    input  stall, req0_valid, req1_valid, req0_addr, req1_addr,
           req0_data, req1_data, chk_addr_a, chk_addr_b,
    output req0_ready, req1_ready, RegWEn, AddrD, DataD, grant_id,
           hazard_a, hazard_b, wr_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter feeding a single register-file write port,
// with a registered write stage, x0 filtering and read-hazard detection.
module regfile_wb_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int RR_EN  = 1
) (
  input logic                   clk,
  input logic                   rst,
  regfile_wb_arbiter_if.slave   bus
);

  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } rr_state_t;

  rr_state_t         rr_last;
  logic              pick0;
  logic              pick1;
  logic              open_gate;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_data;
  logic              sel_addr_nz;

  logic              wen_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;
  logic              gid_q;
  logic [15:0]       cnt_q;

  // req0 wins a tie unless round-robin is on and req0 was the last winner;
  // req1 takes whatever req0 does not.
  always_comb begin
    pick0       = bus.req0_valid &&
                  (!bus.req1_valid || (RR_EN == 0) || (rr_last == LAST_REQ1));
    pick1       = bus.req1_valid && !pick0;
    open_gate   = rst && !bus.stall;
    grant0      = open_gate && pick0;
    grant1      = open_gate && pick1;
    xfer        = grant0 || grant1;
    sel_addr    = grant1 ? bus.req1_addr : bus.req0_addr;
    sel_data    = grant1 ? bus.req1_data : bus.req0_data;
    sel_addr_nz = (sel_addr != '0);
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Write stage: captures the winner, discards x0 writes but keeps the
  // handshake, and holds the last address/data while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      gid_q   <= 1'b0;
      rr_last <= LAST_REQ1;
      cnt_q   <= 16'd0;
    end else if (xfer) begin
      wen_q   <= sel_addr_nz;
      addr_q  <= sel_addr;
      data_q  <= sel_data;
      gid_q   <= grant1;
      rr_last <= grant1 ? LAST_REQ1 : LAST_REQ0;
      if (sel_addr_nz) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end else begin
      wen_q <= 1'b0;
    end
  end

  assign bus.RegWEn   = wen_q;
  assign bus.AddrD    = addr_q;
  assign bus.DataD    = data_q;
  assign bus.grant_id = gid_q;
  assign bus.wr_count = cnt_q;

  // x0 never forwards, so a zero address can never flag a hazard.
  assign bus.hazard_a = wen_q && (addr_q == bus.chk_addr_a) && (addr_q != '0);
  assign bus.hazard_b = wen_q && (addr_q == bus.chk_addr_b) && (addr_q != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus
// and compares both against a per-transfer reference model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic [4:0]  ca, cb;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state, index 0 = round-robin DUT, 1 = fixed-priority DUT.
  int          m_last [2];
  logic        m_wen  [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  logic        m_gid  [2];
  logic [15:0] m_cnt  [2];
  int          last_w [2];

  regfile_wb_arbiter_if #(.DWIDTH(32), .AWIDTH(5)) bus_rr ();
  regfile_wb_arbiter_if #(.DWIDTH(32), .AWIDTH(5)) bus_fp ();

  assign bus_rr.stall      = stall;
  assign bus_rr.req0_valid = v0;
  assign bus_rr.req1_valid = v1;
  assign bus_rr.req0_addr  = a0;
  assign bus_rr.req1_addr  = a1;
  assign bus_rr.req0_data  = d0;
  assign bus_rr.req1_data  = d1;
  assign bus_rr.chk_addr_a = ca;
  assign bus_rr.chk_addr_b = cb;
  assign bus_fp.stall      = stall;
  assign bus_fp.req0_valid = v0;
  assign bus_fp.req1_valid = v1;
  assign bus_fp.req0_addr  = a0;
  assign bus_fp.req1_addr  = a1;
  assign bus_fp.req0_data  = d0;
  assign bus_fp.req1_data  = d1;
  assign bus_fp.chk_addr_a = ca;
  assign bus_fp.chk_addr_b = cb;

  regfile_wb_arbiter #(.DWIDTH(32), .AWIDTH(5), .RR_EN(1)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr.slave)
  );

  regfile_wb_arbiter #(.DWIDTH(32), .AWIDTH(5), .RR_EN(0)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Which requester the arbiter should serve this cycle, or -1 for none.
  function automatic int winner(input int k);
    if (!rst || stall) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (!v0 && !v1) return -1;
    if (k == 1) return 0;
    return (m_last[k] == 0) ? 1 : 0;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1;
      m_wen[k]  = 1'b0;
      m_addr[k] = 5'd0;
      m_data[k] = 32'd0;
      m_gid[k]  = 1'b0;
      m_cnt[k]  = 16'd0;
    end
  endtask

  task automatic modelEdge();
    int w [2];
    for (int k = 0; k < 2; k++) w[k] = winner(k);
    for (int k = 0; k < 2; k++) begin
      last_w[k] = w[k];
      if (!rst) begin
        m_last[k] = 1;
        m_wen[k]  = 1'b0;
        m_addr[k] = 5'd0;
        m_data[k] = 32'd0;
        m_gid[k]  = 1'b0;
        m_cnt[k]  = 16'd0;
      end else if (w[k] >= 0) begin
        m_addr[k] = (w[k] == 1) ? a1 : a0;
        m_data[k] = (w[k] == 1) ? d1 : d0;
        m_wen[k]  = (m_addr[k] != 5'd0);
        m_gid[k]  = (w[k] == 1);
        m_last[k] = w[k];
        if (m_addr[k] != 5'd0) m_cnt[k] = m_cnt[k] + 16'd1;
      end else begin
        m_wen[k] = 1'b0;
      end
    end
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkDut(input string step, input int k, input logic r0, input logic r1,
                          input logic wen, input logic [4:0] addr, input logic [31:0] data,
                          input logic gid, input logic ha, input logic hb, input logic [15:0] cnt);
    int    w;
    string p;
    logic  eha, ehb;
    w   = winner(k);
    p   = {step, (k == 1) ? "/fp/" : "/rr/"};
    eha = m_wen[k] && (m_addr[k] == ca) && (m_addr[k] != 5'd0);
    ehb = m_wen[k] && (m_addr[k] == cb) && (m_addr[k] != 5'd0);
    checkOne({p, "ready0"},   32'(r0),   32'(w == 0));
    checkOne({p, "ready1"},   32'(r1),   32'(w == 1));
    checkOne({p, "RegWEn"},   32'(wen),  32'(m_wen[k]));
    checkOne({p, "AddrD"},    32'(addr), 32'(m_addr[k]));
    checkOne({p, "DataD"},    data,      m_data[k]);
    checkOne({p, "grant_id"}, 32'(gid),  32'(m_gid[k]));
    checkOne({p, "hazard_a"}, 32'(ha),   32'(eha));
    checkOne({p, "hazard_b"}, 32'(hb),   32'(ehb));
    checkOne({p, "wr_count"}, 32'(cnt),  32'(m_cnt[k]));
  endtask

  task automatic checkOutput(input string step);
    checkDut(step, 0, bus_rr.req0_ready, bus_rr.req1_ready, bus_rr.RegWEn, bus_rr.AddrD,
             bus_rr.DataD, bus_rr.grant_id, bus_rr.hazard_a, bus_rr.hazard_b, bus_rr.wr_count);
    checkDut(step, 1, bus_fp.req0_ready, bus_fp.req1_ready, bus_fp.RegWEn, bus_fp.AddrD,
             bus_fp.DataD, bus_fp.grant_id, bus_fp.hazard_a, bus_fp.hazard_b, bus_fp.wr_count);
  endtask

  task automatic applyStimulus(input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                               input logic iv1, input logic [4:0] ia1, input logic [31:0] id1,
                               input logic ist);
    v0 = iv0; a0 = ia0; d0 = id0;
    v1 = iv1; a1 = ia1; d1 = id1;
    stall = ist;
  endtask

  // Check mid-cycle, then advance the model across the rising edge.
  task automatic tick(input string step);
    @(negedge clk);
    checkOutput(step);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    rst = 1'b0;
    #1;
    modelReset();
    tick("inreset");
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    ca = 5'd0;
    cb = 5'd0;
    last_w[0] = -1;
    last_w[1] = -1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    #1 rst = 1'b0;
    modelReset();
    #1 checkOutput("reset");
    tick("reset_hold");
    tick("reset_hold");
    rst = 1'b1;

    // Ties: round-robin alternates starting from req0, fixed priority keeps req0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd3, 32'h3333_0000 + 32'(i), 1'b1, 5'd4, 32'h4444_0000 + 32'(i), 1'b0);
      tick("tie");
      checkOne("tie/rr/grant_seq", 32'(bus_rr.grant_id), 32'(i % 2));
      checkOne("tie/fp/grant_seq", 32'(bus_fp.grant_id), 32'd0);
    end
    checkOne("tie/rr/count4", 32'(bus_rr.wr_count), 32'd4);
    checkOne("tie/fp/count4", 32'(bus_fp.wr_count), 32'd4);

    doReset();
    applyStimulus(1'b1, 5'd15, 32'hDEAD_BEAF, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    checkOne("single/rr/ready0", 32'(bus_rr.req0_ready), 32'd1);
    checkOne("single/fp/ready0", 32'(bus_fp.req0_ready), 32'd1);
    tick("single");
    checkOne("single/RegWEn",   32'(bus_rr.RegWEn),   32'd1);
    checkOne("single/AddrD",    32'(bus_rr.AddrD),    32'd15);
    checkOne("single/DataD",    bus_rr.DataD,         32'hDEAD_BEAF);
    checkOne("single/grant_id", 32'(bus_rr.grant_id), 32'd0);
    checkOne("single/wr_count", 32'(bus_rr.wr_count), 32'd1);

    // x0 writes complete the handshake but never commit.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678, 1'b0);
    #1;
    checkOne("x0/rr/ready1", 32'(bus_rr.req1_ready), 32'd1);
    checkOne("x0/fp/ready1", 32'(bus_fp.req1_ready), 32'd1);
    tick("x0");
    checkOne("x0/RegWEn",   32'(bus_rr.RegWEn),   32'd0);
    checkOne("x0/wr_count", 32'(bus_rr.wr_count), 32'd1);
    checkOne("x0/grant_id", 32'(bus_rr.grant_id), 32'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd10, 32'h0A0A_0A0A, 1'b1, 5'd11, 32'h0B0B_0B0B, 1'b1);
      #1;
      checkOne("stall/rr/ready0", 32'(bus_rr.req0_ready), 32'd0);
      checkOne("stall/rr/ready1", 32'(bus_rr.req1_ready), 32'd0);
      tick("stall");
      checkOne("stall/RegWEn", 32'(bus_rr.RegWEn), 32'd0);
    end
    stall = 1'b0;
    #1;
    checkOne("unstall/rr/ready0", 32'(bus_rr.req0_ready), 32'd1);
    checkOne("unstall/fp/ready0", 32'(bus_fp.req0_ready), 32'd1);
    tick("unstall");

    ca = 5'd7;
    cb = 5'd8;
    applyStimulus(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, 1'b0);
    tick("hazard");
    checkOne("hazard/hazard_a", 32'(bus_rr.hazard_a), 32'd1);
    checkOne("hazard/hazard_b", 32'(bus_rr.hazard_b), 32'd0);
    checkOne("hazard/DataD",    bus_rr.DataD,         32'hA5A5_A5A5);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick("hazard_idle");
    checkOne("hazard_idle/hazard_a", 32'(bus_rr.hazard_a), 32'd0);

    // Reset asserted between edges must clear the write stage immediately.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0099, 1'b0);
    tick("prereset");
    checkOne("prereset/RegWEn", 32'(bus_rr.RegWEn), 32'd1);
    applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkOne("midreset/RegWEn",   32'(bus_rr.RegWEn),     32'd0);
    checkOne("midreset/wr_count", 32'(bus_rr.wr_count),   32'd0);
    checkOne("midreset/ready0",   32'(bus_rr.req0_ready), 32'd0);
    checkOne("midreset/ready1",   32'(bus_fp.req1_ready), 32'd0);
    modelReset();
    checkOutput("midreset");
    tick("midreset_hold");
    tick("midreset_hold");
    rst = 1'b1;
    #1;
    checkOne("firsttie/rr/ready0", 32'(bus_rr.req0_ready), 32'd1);
    checkOne("firsttie/rr/ready1", 32'(bus_rr.req1_ready), 32'd0);
    tick("firsttie");
    checkOne("firsttie/rr/grant_id", 32'(bus_rr.grant_id), 32'd0);

    // Random traffic; a requester holds its request until both arbiters took it.
    for (int n = 0; n < 300; n++) begin
      if (!(v0 && !(last_w[0] == 0 && last_w[1] == 0))) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = 5'($urandom_range(0, 7));
        d0 = $urandom;
      end
      if (!(v1 && !(last_w[0] == 1 && last_w[1] == 1))) begin
        v1 = ($urandom_range(0, 3) != 0);
        a1 = 5'($urandom_range(0, 7));
        d1 = $urandom;
      end
      stall = ($urandom_range(0, 5) == 0);
      ca = ($urandom_range(0, 1) == 1) ? m_addr[0] : 5'($urandom_range(0, 31));
      cb = 5'($urandom_range(0, 7));
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DWIDTH, default 32, data width of the register-file write port.
REQ-002 Parameter AWIDTH, default 5, register address width.
REQ-003 Parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with req0 winning.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-006 stall  input  1  pipeline hold; 1 blocks all grants.
REQ-007 req0_valid, req1_valid  input  1 each  writeback request present.
REQ-008 req0_addr, req1_addr  input  AWIDTH each  destination register.
REQ-009 req0_data, req1_data  input  DWIDTH each  writeback data.
REQ-010 req0_ready, req1_ready  output  1 each  grant; the transfer completes on a rising edge where valid and ready are both 1.
REQ-011 RegWEn  output  1  register-file write enable, registered.
REQ-012 AddrD  output  AWIDTH  register-file write address, registered.
REQ-013 DataD  output  DWIDTH  register-file write data, registered.
REQ-014 grant_id  output  1  source of the write currently on AddrD/DataD, registered.
REQ-015 chk_addr_a, chk_addr_b  input  AWIDTH each  read addresses to check for a pending write.
REQ-016 hazard_a, hazard_b  output  1 each  the write stage holds the checked register.
REQ-017 wr_count  output  16  count of committed nonzero-address writes.

Function
REQ-018 Readiness: reqN_ready SHALL be combinational from the valids, stall, rst and the arbitration state. At most one ready SHALL be 1 in any cycle.
REQ-019 Readiness: with stall=1 or rst=0, both readies SHALL be 0.
REQ-020 Only one valid: that requester SHALL be granted in the same cycle.
REQ-021 Both valid, RR_EN=1: grant the requester other than rr_last.
REQ-022 Both valid, RR_EN=0: grant req0.
REQ-023 rr_last is a 1-bit register. It SHALL update to the granted id on every completed transfer and hold otherwise.
REQ-024 On a completed transfer at edge N, the following SHALL hold during cycle N+1 (latency 1):
- RegWEn = 1, except 0 when the captured address is 0 (x0 writes are discarded).
- AddrD and DataD = the captured address and data.
- grant_id = the granted id.
REQ-025 A request to address 0 SHALL still complete its handshake.
REQ-026 In any cycle after an edge with no completed transfer: RegWEn SHALL be 0; AddrD, DataD and grant_id SHALL hold their values.
REQ-027 wr_count SHALL increment by 1 at each edge where a transfer with nonzero address completes. It SHALL wrap 0xFFFF -> 0x0000.
REQ-028 hazard_x = RegWEn AND (AddrD == chk_addr_x) AND (AddrD != 0), combinational. The forwarding value for a hazard is DataD.
REQ-029 A requester SHALL hold addr/data stable while valid=1 and ready=0; the block is not required to tolerate violations.
REQ-030 Both requesters may target the same register. They SHALL then be serialized in grant order, and the later grant is the final value.
REQ-031 Deasserting stall SHALL allow a grant in the same cycle.

Reset
REQ-032 On rst=0, asynchronously: RegWEn=0, AddrD=0, DataD=0, grant_id=0, rr_last=1, wr_count=0.
REQ-033 During reset the readies and hazards SHALL be 0.
REQ-034 A transfer whose edge coincides with rst=0 SHALL be lost, with no write and no count.
REQ-035 After rst rises, the first tie SHALL go to req0.
REQ-036 Reset asserted while RegWEn=1 SHALL drop RegWEn to 0 without waiting for a clock edge.

Verification
REQ-037 Bench SHALL cover a single request: req0 valid, addr 15, data 0xDEADBEAF -> req0_ready=1 the same cycle; next cycle RegWEn=1, AddrD=15, DataD=0xDEADBEAF, grant_id=0, wr_count=1.
REQ-038 Bench SHALL cover round-robin: RR_EN=1, both valid for 4 cycles (addr 3 and 4) -> grant_id sequence 0,1,0,1 and wr_count=4. With RR_EN=0 the same stimulus gives grant_id 0,0,0,0.
REQ-039 Bench SHALL cover an x0 write: req1 addr 0, data 0x12345678 -> req1_ready=1; next cycle RegWEn=0 and wr_count unchanged.
REQ-040 Bench SHALL cover stall: stall=1 with both valid for 3 cycles -> both readies 0 and RegWEn=0 throughout; stall=0 -> req0 granted that cycle.
REQ-041 Bench SHALL cover a hazard: write addr 7, data 0xA5A5A5A5 in the write stage with chk_addr_a=7 and chk_addr_b=8 -> hazard_a=1, hazard_b=0, DataD=0xA5A5A5A5. The following idle cycle gives hazard_a=0.
REQ-042 Bench SHALL cover reset mid-operation: rst=0 mid-cycle while RegWEn=1 -> RegWEn=0 immediately, wr_count=0, readies 0 until rst=1.
